// File: rtl/apb3_pwm_array.sv
// apb3_pwm_array: APB3 slave driving NUM_CH PWM outputs from one shared
// period counter. PERIOD and DUTY are double-buffered: software writes the
// pending copies, and a counter wrap loads them into the active copies, so
// an update never takes effect part-way through a period.
module apb3_pwm_array #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned PRESCALE   = 100,
    parameter int unsigned RST_PERIOD = 20000
) (
    input  logic              PCLK,
    input  logic              PRESETN,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [7:0]        PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic [NUM_CH-1:0] PWM_OUT,
    output logic              IRQ
);

    localparam int unsigned      PS_W       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]  PS_LAST    = PS_W'(PRESCALE - 1);
    localparam logic [PS_W-1:0]  PS_ONE     = PS_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] PERIOD_RST = CNT_W'(RST_PERIOD);
    localparam logic [5:0]       W_CTRL     = 6'd0;
    localparam logic [5:0]       W_STATUS   = 6'd1;
    localparam logic [5:0]       W_PERIOD   = 6'd2;
    localparam logic [5:0]       W_IRQEN    = 6'd3;
    localparam logic [5:0]       W_DUTY0    = 6'd4;
    localparam logic [5:0]       W_DUTYEND  = 6'(4 + NUM_CH);

    // Register state
    logic [NUM_CH-1:0] ctrl_q, ctrl_d;
    logic              wrap_q, wrap_d;
    logic              irq_en_q, irq_en_d;
    logic [CNT_W-1:0]  per_pend_q, per_pend_d;
    logic [CNT_W-1:0]  per_act_q, per_act_d;
    logic [CNT_W-1:0]  duty_pend_q [NUM_CH];
    logic [CNT_W-1:0]  duty_pend_d [NUM_CH];
    logic [CNT_W-1:0]  duty_act_q  [NUM_CH];
    logic [CNT_W-1:0]  duty_act_d  [NUM_CH];
    logic [PS_W-1:0]   presc_q, presc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NUM_CH-1:0] pwm_q, pwm_d;
    logic              irq_q, irq_d;

    // Bus decode
    logic [5:0] word;
    logic [5:0] duty_idx;
    logic       duty_hit;
    logic       mapped;
    logic       access;
    logic       wr_en;
    logic       tick;
    logic       wrap_evt;
    logic       unused_ok;

    assign word      = PADDR[7:2];
    assign duty_hit  = (word >= W_DUTY0) && (word < W_DUTYEND);
    assign duty_idx  = word - W_DUTY0;
    assign mapped    = (word < W_DUTY0) || duty_hit;
    assign access    = PSEL & PENABLE;
    assign wr_en     = access & PWRITE & mapped;
    assign PSLVERR   = access & ~mapped;
    assign PREADY    = 1'b1;
    assign PWM_OUT   = pwm_q;
    assign IRQ       = irq_q;
    assign unused_ok = ^{PADDR[1:0], PWDATA};

    // Read mux: combinational, zero when idle, writing or unmapped
    always_comb begin
        PRDATA = '0;
        if (PSEL && !PWRITE && mapped) begin
            case (word)
                W_CTRL:   PRDATA[NUM_CH-1:0] = ctrl_q;
                W_STATUS: PRDATA[0]          = wrap_q;
                W_PERIOD: PRDATA[CNT_W-1:0]  = per_pend_q;
                W_IRQEN:  PRDATA[0]          = irq_en_q;
                default: begin
                    for (int unsigned i = 0; i < NUM_CH; i++) begin
                        if (duty_idx == 6'(i)) begin
                            PRDATA[CNT_W-1:0] = duty_pend_q[i];
                        end
                    end
                end
            endcase
        end
    end

    // Next-state: register writes, prescaler, counter, buffer load, outputs
    always_comb begin
        ctrl_d      = ctrl_q;
        irq_en_d    = irq_en_q;
        per_pend_d  = per_pend_q;
        duty_pend_d = duty_pend_q;
        per_act_d   = per_act_q;
        duty_act_d  = duty_act_q;
        cnt_d       = cnt_q;

        if (wr_en) begin
            case (word)
                W_CTRL:   ctrl_d     = PWDATA[NUM_CH-1:0];
                W_PERIOD: per_pend_d = PWDATA[CNT_W-1:0];
                W_IRQEN:  irq_en_d   = PWDATA[0];
                default: begin
                    for (int unsigned i = 0; i < NUM_CH; i++) begin
                        if (duty_hit && (duty_idx == 6'(i))) begin
                            duty_pend_d[i] = PWDATA[CNT_W-1:0];
                        end
                    end
                end
            endcase
        end

        tick     = (presc_q == PS_LAST);
        presc_d  = tick ? '0 : presc_q + PS_ONE;
        wrap_evt = tick && ((per_act_q == '0) || (cnt_q == per_act_q - CNT_ONE));

        // The wrap samples the pending copies before this edge's write lands,
        // so a write on the wrap edge waits for the following wrap.
        if (tick) begin
            if (wrap_evt) begin
                cnt_d      = '0;
                per_act_d  = per_pend_q;
                duty_act_d = duty_pend_q;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end

        // Set has priority over write-1-to-clear
        wrap_d = wrap_evt | (wrap_q & ~(wr_en && (word == W_STATUS) && PWDATA[0]));

        // Compare against the values being loaded so the output lines up
        // with the counter (and with a freshly loaded duty) on the same edge.
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            pwm_d[i] = ctrl_q[i] && (per_act_d != '0) && (duty_act_d[i] > cnt_d);
        end

        irq_d = wrap_q & irq_en_q;
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            ctrl_q     <= '0;
            wrap_q     <= 1'b0;
            irq_en_q   <= 1'b0;
            per_pend_q <= PERIOD_RST;
            per_act_q  <= PERIOD_RST;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                duty_pend_q[i] <= '0;
                duty_act_q[i]  <= '0;
            end
            presc_q    <= '0;
            cnt_q      <= '0;
            pwm_q      <= '0;
            irq_q      <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            wrap_q     <= wrap_d;
            irq_en_q   <= irq_en_d;
            per_pend_q <= per_pend_d;
            per_act_q  <= per_act_d;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                duty_pend_q[i] <= duty_pend_d[i];
                duty_act_q[i]  <= duty_act_d[i];
            end
            presc_q    <= presc_d;
            cnt_q      <= cnt_d;
            pwm_q      <= pwm_d;
            irq_q      <= irq_d;
        end
    end

endmodule

// File: tb/tb_apb3_pwm_array.sv
// Bench for apb3_pwm_array: dut0 runs with PRESCALE=1 and default reset
// period, dut1 with PRESCALE=4 and a short reset period. Both share the bus.
module tb_apb3_pwm_array;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        psel, penable, pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata0, prdata1;
    logic        pready0, pready1, pslverr0, pslverr1;
    logic [3:0]  pwm0, pwm1;
    logic        irq0, irq1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    apb3_pwm_array #(.NUM_CH(4), .CNT_W(16), .PRESCALE(1), .RST_PERIOD(20000)) dut0 (
        .PCLK(clk), .PRESETN(rst_n), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata0), .PREADY(pready0),
        .PSLVERR(pslverr0), .PWM_OUT(pwm0), .IRQ(irq0)
    );

    apb3_pwm_array #(.NUM_CH(4), .CNT_W(16), .PRESCALE(4), .RST_PERIOD(6)) dut1 (
        .PCLK(clk), .PRESETN(rst_n), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata1), .PREADY(pready1),
        .PSLVERR(pslverr1), .PWM_OUT(pwm1), .IRQ(irq1)
    );

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic timed_out(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out waiting for PWM edge", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One APB transfer; returns at posedge+1 after the access-phase edge
    task automatic apb(input bit wr, input logic [7:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rd0, output logic [31:0] rd1, output logic err);
        @(posedge clk); #1;
        psel = 1'b1; pwrite = wr; penable = 1'b0; paddr = addr; pwdata = wdata;
        @(posedge clk); #1;
        penable = 1'b1;
        #1;
        rd0 = prdata0; rd1 = prdata1; err = pslverr0;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic wr(input logic [7:0] addr, input logic [31:0] wdata);
        logic [31:0] r0, r1;
        logic        e;
        apb(1'b1, addr, wdata, r0, r1, e);
    endtask

    task automatic rd(input logic [7:0] addr, output logic [31:0] r0, output logic [31:0] r1);
        logic e;
        apb(1'b0, addr, 32'h0, r0, r1, e);
    endtask

    function automatic logic get_pwm(input bit which, input int ch);
        return which ? pwm1[ch] : pwm0[ch];
    endfunction

    // Leaves the bench on the first sample where the output has just risen
    task automatic wait_rise(input bit which, input int ch, input int limit, output bit ok);
        int n = 0;
        while (get_pwm(which, ch) && n < limit) begin step(); n++; end
        while (!get_pwm(which, ch) && n < limit) begin step(); n++; end
        ok = (n < limit);
    endtask

    // High time and full period in samples, starting and ending on a rise
    task automatic measure(input string name, input bit which, input int ch, input int limit,
                           output int hi, output int per);
        bit ok;
        int lo;
        hi = 0; lo = 0;
        wait_rise(which, ch, limit, ok);
        if (!ok) timed_out(name);
        while (get_pwm(which, ch) && hi < 64) begin step(); hi++; end
        while (!get_pwm(which, ch) && lo < 64) begin step(); lo++; end
        per = hi + lo;
    endtask

    function automatic vec_t V(input bit w, input logic [7:0] a, input logic [31:0] d,
                               input logic [31:0] er, input bit ee);
        vec_t v;
        v.wr = w; v.addr = a; v.wdata = d; v.exp_rdata = er; v.exp_err = ee;
        return v;
    endfunction

    task automatic run_table(input string tag, input vec_t tbl[$]);
        logic [31:0] r0, r1;
        logic        e;
        foreach (tbl[k]) begin
            apb(tbl[k].wr, tbl[k].addr, tbl[k].wdata, r0, r1, e);
            chk($sformatf("%s[%0d] pslverr @%0h", tag, k, tbl[k].addr), {31'b0, e}, {31'b0, tbl[k].exp_err});
            if (!tbl[k].wr)
                chk($sformatf("%s[%0d] prdata @%0h", tag, k, tbl[k].addr), r0, tbl[k].exp_rdata);
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        t_map[$];
        vec_t        t_rst[$];
        logic [31:0] r0, r1;
        int          hi, per, n;
        bit          ok;

        // Register map checks straight after reset (dut0 view)
        t_map.push_back(V(0, 8'h08, 0, 32'd20000, 0));
        t_map.push_back(V(0, 8'h10, 0, 32'h0, 0));
        t_map.push_back(V(0, 8'h20, 0, 32'h0, 1));        // DUTY[4] does not exist
        t_map.push_back(V(1, 8'h40, 32'hFFFF_FFFF, 0, 1)); // unmapped write
        t_map.push_back(V(1, 8'h20, 32'h0000_0055, 0, 1)); // DUTY[4] write
        t_map.push_back(V(0, 8'h00, 0, 32'h0, 0));
        t_map.push_back(V(0, 8'h04, 0, 32'h0, 0));
        t_map.push_back(V(0, 8'h0C, 0, 32'h0, 0));
        t_map.push_back(V(0, 8'h1C, 0, 32'h0, 0));
        t_map.push_back(V(0, 8'h44, 0, 32'h0, 1));
        t_map.push_back(V(1, 8'h08, 32'h0001_000A, 0, 0)); // upper bits dropped
        t_map.push_back(V(0, 8'h08, 0, 32'd10, 0));
        t_map.push_back(V(1, 8'h10, 32'd3, 0, 0));
        t_map.push_back(V(0, 8'h10, 0, 32'd3, 0));
        t_map.push_back(V(1, 8'h00, 32'h1F, 0, 0));
        t_map.push_back(V(0, 8'h00, 0, 32'hF, 0));
        t_map.push_back(V(1, 8'h00, 32'h1, 0, 0));
        t_map.push_back(V(0, 8'h03, 0, 32'h1, 0));         // byte bits ignored
        t_map.push_back(V(1, 8'h0C, 32'hFFFF_FFFF, 0, 0));
        t_map.push_back(V(0, 8'h0C, 0, 32'h1, 0));
        t_map.push_back(V(1, 8'h0C, 32'h0, 0, 0));

        // Values expected after the mid-run reset
        t_rst.push_back(V(0, 8'h00, 0, 32'h0, 0));
        t_rst.push_back(V(0, 8'h04, 0, 32'h0, 0));
        t_rst.push_back(V(0, 8'h08, 0, 32'd20000, 0));
        t_rst.push_back(V(0, 8'h0C, 0, 32'h0, 0));
        t_rst.push_back(V(0, 8'h10, 0, 32'h0, 0));
        t_rst.push_back(V(0, 8'h14, 0, 32'h0, 0));
        t_rst.push_back(V(0, 8'h18, 0, 32'h0, 0));
        t_rst.push_back(V(0, 8'h1C, 0, 32'h0, 0));

        rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        #32 rst_n = 1'b1;
        step();

        chk("reset pwm0", {28'b0, pwm0}, 32'h0);
        chk("reset irq0", {31'b0, irq0}, 32'h0);
        chk("pready", {31'b0, pready0}, 32'h1);
        chk("idle prdata", prdata0, 32'h0);

        run_table("map", t_map);

        // First wrap loads PERIOD=10 / DUTY0=3 after the 20000-tick reset frame
        measure("basic", 1'b0, 0, 21000, hi, per);
        chk("basic high", hi, 3);
        chk("basic period", per, 10);
        chk("basic pwm[3:1]", {28'b0, pwm0[3:1], 1'b0}, 32'h0);

        // Mid-period duty update leaves the current period alone
        wr(8'h10, 32'd7);
        chk("dbuf current low at cnt3", {31'b0, pwm0[0]}, 32'h0);
        measure("dbuf next", 1'b0, 0, 40, hi, per);
        chk("dbuf next high", hi, 7);
        chk("dbuf next period", per, 10);

        // Write landing on the wrap edge: one extra period at the old duty
        repeat (7) @(posedge clk);
        wr(8'h10, 32'd3);
        chk("wrap-edge write pwm", {31'b0, pwm0[0]}, 32'h1);
        n = 0;
        while (pwm0[0] && n < 64) begin step(); n++; end
        chk("wrap-edge old duty", n, 7);
        measure("wrap-edge delayed", 1'b0, 0, 40, hi, per);
        chk("wrap-edge delayed high", hi, 3);

        // Duty boundaries
        wr(8'h14, 32'd0);
        wr(8'h18, 32'd10);
        wr(8'h1C, 32'd15);
        wr(8'h00, 32'hF);
        repeat (25) step();
        for (int c = 0; c < 20; c++) begin
            chk($sformatf("bound cyc%0d pwm[3:1]", c), {29'b0, pwm0[3:1]}, 32'h6);
            step();
        end

        // Period 0: outputs low, wrap on every tick
        wr(8'h08, 32'd0);
        repeat (15) step();
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("per0 cyc%0d pwm", c), {28'b0, pwm0}, 32'h0);
            step();
        end
        wr(8'h04, 32'h1);
        rd(8'h04, r0, r1);
        chk("per0 wrap resets each tick", r0, 32'h1);

        // Interrupt
        wr(8'h08, 32'd10);
        wr(8'h0C, 32'h1);
        wait_rise(1'b0, 0, 40, ok);
        if (!ok) timed_out("irq sync");
        repeat (3) step();
        wr(8'h04, 32'h1);
        wait_rise(1'b0, 0, 40, ok);
        if (!ok) timed_out("irq rise");
        chk("irq low on wrap edge", {31'b0, irq0}, 32'h0);
        step();
        chk("irq high after wrap", {31'b0, irq0}, 32'h1);
        wr(8'h04, 32'h1);
        chk("irq high on clear edge", {31'b0, irq0}, 32'h1);
        step();
        chk("irq low after clear", {31'b0, irq0}, 32'h0);
        rd(8'h04, r0, r1);
        chk("status cleared", r0, 32'h0);

        // Clear coinciding with a wrap: set wins
        wait_rise(1'b0, 0, 40, ok);
        if (!ok) timed_out("irq set-wins sync");
        repeat (7) @(posedge clk);
        wr(8'h04, 32'h1);
        chk("set-wins irq edge", {31'b0, irq0}, 32'h1);
        step();
        chk("set-wins irq after", {31'b0, irq0}, 32'h1);
        rd(8'h04, r0, r1);
        chk("set-wins status", r0, 32'h1);

        // Prescaled PWM on dut1, plain PWM on dut0 with same settings
        wr(8'h08, 32'd5);
        wr(8'h10, 32'd2);
        wr(8'h00, 32'h1);
        repeat (100) step();
        measure("presc", 1'b1, 0, 60, hi, per);
        chk("presc high", hi, 8);
        chk("presc period", per, 20);
        measure("nopresc", 1'b0, 0, 20, hi, per);
        chk("nopresc high", hi, 2);
        chk("nopresc period", per, 5);

        // Asynchronous reset in the middle of the high phase
        wait_rise(1'b1, 0, 60, ok);
        if (!ok) timed_out("reset sync");
        repeat (2) step();
        chk("pre-reset pwm1", {31'b0, pwm1[0]}, 32'h1);
        #3 rst_n = 1'b0;
        #1;
        chk("async reset pwm1", {28'b0, pwm1}, 32'h0);
        chk("async reset irq0", {31'b0, irq0}, 32'h0);
        repeat (2) @(posedge clk);
        #4 rst_n = 1'b1;
        rd(8'h08, r0, r1);
        chk("dut1 reset period", r1, 32'd6);
        run_table("rst", t_rst);
        chk("post-reset pwm0", {28'b0, pwm0}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
